mccpu: RTL and testbench
========================

# mccpu

Multi-cycle MIPS-subset processor core: the next generation of the team's single-cycle CPU. It moves from separate, always-ready instruction and data ports to one shared memory port with a request/ready handshake, so arbitrary wait states are tolerated. It sequences every instruction through an explicit state machine. It sits between the board-level memory/peripheral fabric and the debug/display logic, and reports each retired instruction and any halt.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HALT_ON_ILLEGAL, 1, 1: an unknown opcode/funct enters HALT; 0: it retires as a NOP.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata  out  32  store data; valid when mem_req && mem_we.
- mem_rdata  in  32  read data; sampled in the cycle where mem_req && mem_ready.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- retire_pc  out  32  PC of the instruction flagged by retire.
- halted  out  1  core is in HALT.
- reg_sel  in  5  debug register select (MCCPU_DEBUG_EN only).
- reg_data  out  32  debug register value (MCCPU_DEBUG_EN only).

## Operation
- ISA: addu, subu, and, or, slt, sll, srl, jr, addiu, ori, lui (immediate << 16), lw, sw, beq, bne, j, jal.
- Immediate extension: addiu, lw, sw, beq, bne sign-extend; ori zero-extends.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready, IR <= mem_rdata, PC <= PC+4, go to DECODE.
- DECODE: read rs/rt into registers A and B. Compute the branch target as PC + (sext(imm) << 2). Go to EXEC, or to HALT when the instruction is illegal and HALT_ON_ILLEGAL=1.
- EXEC, ALU and immediate ops: ALUOut is registered, go to WB.
- EXEC, lw/sw: address is computed, go to MEM.
- EXEC, beq/bne: PC <= target if taken, retire, go to FETCH.
- EXEC, j: PC <= {PC[31:28], imm26, 2'b00}, retire, go to FETCH.
- EXEC, jal: same PC update as j, plus r31 <= PC (already +4); retire, go to FETCH.
- EXEC, jr: PC <= A, retire, go to FETCH.
- MEM: mem_req=1, mem_addr = ALUOut & ~3. Stay in MEM until mem_ready.
  - sw: mem_wdata = B; retire, go to FETCH.
  - lw: MDR <= mem_rdata, go to WB.
- WB: write rd (R-type), rt (I-type) or MDR (lw); retire, go to FETCH.
- Writes to r0 are discarded; r0 always reads 0.
- HALT: absorbing; mem_req=0, halted=1. Only rst exits.
- All arithmetic is mod 2^32, with no overflow traps. slt compares signed. The shift amount is instr[10:6].
- The low two bits of unaligned lw/sw addresses are ignored. There is no exception.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, all GPRs 0, mem_req=0 during reset, retire=0, retire_pc=0, halted=0.
- mem_req asserts in the first cycle after rst deasserts.
- Handshake rules:
  - A transfer completes on a rising edge with mem_req && mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until completion.
- Cycle counts with zero wait states:
  - R-type/ALU-imm: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne/j/jal/jr: 3.
  - Each cycle mem_ready is low in FETCH or MEM adds one cycle.
- retire is high in the final state cycle of each instruction. Consecutive instructions therefore produce pulses at least 3 cycles apart.
- rst asserted mid-transfer aborts it immediately: mem_req drops asynchronously and any pending write is not issued again.

## Configuration
- MCCPU_DEBUG_EN defined: the reg_sel/reg_data ports exist. reg_data = GPR[reg_sel], combinational, with r0 reading 0.
- MCCPU_DEBUG_EN undefined: both ports are absent and there is no extra read port on the register file.

## Structure
- Package mccpu_pkg holds:
  - the state enum;
  - opcode/funct constants;
  - ALU op enum;
  - RESET_PC default.
- One sub-module, mccpu_rf: 32x32 register file with 2 read ports, 1 write port, async reset, and the optional debug port.
- ALU, decode and FSM live in mccpu.

## Test plan
- Zero-wait program addiu r1,r0,5; addiu r2,r0,-3; addu r3,r1,r2 -> r3=2, retire pulses 4 cycles apart, retire_pc 0x3000/0x3004/0x3008.
- sw r3,0(r0) then lw r4,0(r0), with a memory model that holds mem_ready low 2 cycles per request:
  - -> single write of 2 to address 0;
  - -> r4=2;
  - -> lw takes 5+4 cycles (2 wait cycles on the fetch and 2 on the load);
  - -> outputs stable while waiting.
- beq r1,r1,-1 (self-loop) -> PC returns to the same address every 3 cycles. bne r1,r1 -> falls through to PC+4.
- jal 0x3100 then jr r31 at 0x3100 -> r31=0x3004, next fetch at 0x3004.
- Opcode 6'h3F with HALT_ON_ILLEGAL=1 -> halted=1, mem_req stays 0, no retire; rst clears it and fetch restarts at RESET_PC.
- addiu r0,r0,7 -> r0 reads 0 via reg_data (MCCPU_DEBUG_EN). rst asserted mid-MEM -> mem_req=0 the same cycle, PC=RESET_PC.

Source files
------------

// File: rtl/mccpu_pkg.sv
// Shared types and constants for the mccpu multi-cycle core: FSM states,
// opcode/funct encodings, ALU operations and the ALU evaluation helper.
package mccpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned NUM_REGS         = 32;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

  // Shifts operate on the second operand (rt), matching MIPS sll/srl.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = {31'b0, $signed(x) < $signed(y)};
      ALU_SLL: r = y << sh;
      ALU_SRL: r = y >> sh;
      ALU_LUI: r = {y[15:0], 16'h0000};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mccpu_rf.sv
// mccpu register file: 32x32, two async read ports, one write port, r0 fixed at 0.
// Optional debug read port (reg_sel/reg_data) when MCCPU_DEBUG_EN is defined.
module mccpu_rf
  import mccpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
`ifdef MCCPU_DEBUG_EN
  ,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
`endif
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

`ifdef MCCPU_DEBUG_EN
  assign reg_data = (reg_sel == 5'd0) ? '0 : regs[reg_sel];
`endif

endmodule

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-subset core with one shared req/ready memory port.
// Define MCCPU_DEBUG_EN to expose the reg_sel/reg_data debug register port.
module mccpu
  import mccpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter logic        HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted
`ifdef MCCPU_DEBUG_EN
  ,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
`endif
);

  state_t      state;
  logic [31:0] pc, ir, ir_pc, a, b, alu_out, mdr, target;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext, imm_ext, alu_res;
  alu_op_t     alu_op;
  logic        use_imm, dst_rd, legal;
  logic        is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_rd1, rf_rd2;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign sext    = {{16{ir[15]}}, ir[15:0]};
  assign imm_ext = (opcode == OP_ORI || opcode == OP_LUI) ? {16'h0000, ir[15:0]} : sext;

  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    dst_rd  = 1'b0;
    legal   = 1'b1;
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_alu = 1'b1;
        dst_rd = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_JR:   begin is_alu = 1'b0; is_jr = 1'b1; end
          default: begin is_alu = 1'b0; legal = 1'b0; end
        endcase
      end
      OP_ADDIU: begin is_alu = 1'b1; use_imm = 1'b1; end
      OP_ORI:   begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_OR; end
      OP_LUI:   begin is_alu = 1'b1; use_imm = 1'b1; alu_op = ALU_LUI; end
      OP_LW:    begin is_lw = 1'b1; use_imm = 1'b1; end
      OP_SW:    begin is_sw = 1'b1; use_imm = 1'b1; end
      OP_BEQ:   is_beq = 1'b1;
      OP_BNE:   is_bne = 1'b1;
      OP_J:     is_j = 1'b1;
      OP_JAL:   is_jal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  assign alu_res = alu_eval(alu_op, a, use_imm ? imm_ext : b, shamt);

  // jal links in EXEC (pc already holds return address); everything else writes in WB.
  assign rf_we = (state == S_WB) || (state == S_EXEC && is_jal);
  assign rf_wa = (state == S_EXEC) ? 5'd31 : (dst_rd ? rd : rt);
  assign rf_wd = (state == S_EXEC) ? pc : (is_lw ? mdr : alu_out);

  mccpu_rf u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (rs),
    .ra2      (rt),
    .rd1      (rf_rd1),
    .rd2      (rf_rd2),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd)
`ifdef MCCPU_DEBUG_EN
    ,
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      ir_pc   <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      target  <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          ir_pc <= pc;
          pc    <= pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a      <= rf_rd1;
          b      <= rf_rd2;
          target <= pc + {sext[29:0], 2'b00};
          state  <= (!legal && HALT_ON_ILLEGAL) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            alu_out <= alu_res;
            state   <= S_MEM;
          end else if (is_alu) begin
            alu_out <= alu_res;
            state   <= S_WB;
          end else begin
            if ((is_beq && a == b) || (is_bne && a != b)) pc <= target;
            if (is_j || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
            if (is_jr) pc <= a;
            state <= S_FETCH;
          end
        end
        S_MEM: if (mem_ready) begin
          if (is_lw) begin
            mdr   <= mem_rdata;
            state <= S_WB;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // rst gates the request combinationally so an in-flight transfer aborts at once.
  assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = (state == S_MEM) && is_sw;
  assign mem_addr  = (state == S_MEM) ? {alu_out[31:2], 2'b00} : {pc[31:2], 2'b00};
  assign mem_wdata = b;

  assign retire    = (state == S_WB)
                  || (state == S_EXEC && !is_alu && !is_lw && !is_sw)
                  || (state == S_MEM && is_sw && mem_ready);
  assign retire_pc = ir_pc;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_mccpu.sv
// Scoreboard bench for mccpu: stimulus loads directed programs and queues the
// expected retire/write events; an independent monitor pops and compares them.
module tb_mccpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;
`ifdef MCCPU_DEBUG_EN
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;
`endif

  mccpu #(.RESET_PC(32'h0000_3000), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .retire_pc (retire_pc),
    .halted    (halted)
`ifdef MCCPU_DEBUG_EN
    ,
    .reg_sel   (reg_sel),
    .reg_data  (reg_data)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: program ROM at 0x3000, data RAM at 0x0; wait_n wait cycles per request.
  logic [31:0] prog [256];
  logic [31:0] dmem [256];
  int          wait_n = 0;
  int          wcnt = 0;

  assign mem_ready = mem_req && (wcnt >= wait_n);
  assign mem_rdata = (mem_addr[13:12] == 2'b11) ? prog[mem_addr[9:2]] : dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    if (mem_req && mem_ready && mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    int          gap;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_ret(input logic [31:0] pc, input int gap);
    ev_t e;
    e.is_wr = 1'b0; e.a = pc; e.d = '0; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.is_wr = 1'b1; e.a = addr; e.d = data; e.gap = 0;
    sb.push_back(e);
  endtask

  // Monitor: compares every retire pulse and completed write against the queue,
  // and checks request stability across wait cycles.
  initial begin
    int          cyc, last_ret;
    logic        prev_wait;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    ev_t         e;
    cyc = 0; last_ret = 0; prev_wait = 1'b0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (mem_req && mem_ready && mem_we) begin
          if (sb.size() == 0 || !sb[0].is_wr) begin
            checks++; failures++;
            $display("FAIL unexpected_write actual=%h@%h required=none", mem_wdata, mem_addr);
          end else begin
            e = sb.pop_front();
            chk("write_addr", mem_addr, e.a);
            chk("write_data", mem_wdata, e.d);
          end
        end
        if (retire) begin
          if (sb.size() == 0 || sb[0].is_wr) begin
            checks++; failures++;
            $display("FAIL unexpected_retire actual=%h required=none", retire_pc);
          end else begin
            e = sb.pop_front();
            chk("retire_pc", retire_pc, e.a);
            if (e.gap != 0) chk("retire_gap", 32'(cyc - last_ret), 32'(e.gap));
          end
          last_ret = cyc;
        end
        if (prev_wait && mem_req) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_we", {31'b0, mem_we}, {31'b0, p_we});
          if (p_we) chk("hold_wdata", mem_wdata, p_wdata);
        end
        prev_wait = mem_req && !mem_ready;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    prog[addr[9:2]] = w;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
  endtask

  task automatic release_rst(input int wn);
    wait_n = wn;
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) begin
      @(negedge clk); #2;
    end
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic assert_rst();
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  localparam logic [31:0] SELF = 32'h1000_FFFF;  // beq r0,r0,-1

  initial begin
    clear_prog();
    #3;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_retire_pc", retire_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // Zero-wait arithmetic: r3 = 5 + -3 = 2, stored to 0x10, then self-loop.
    put(32'h3000, ei(6'h09, 5'd0, 5'd1, 16'd5));
    put(32'h3004, ei(6'h09, 5'd0, 5'd2, 16'hFFFD));
    put(32'h3008, er(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
    put(32'h300C, ei(6'h2B, 5'd0, 5'd3, 16'h0010));
    put(32'h3010, SELF);
    push_ret(32'h3000, 0); push_ret(32'h3004, 4); push_ret(32'h3008, 4);
    push_wr(32'h10, 32'd2); push_ret(32'h300C, 4);
    push_ret(32'h3010, 3); push_ret(32'h3010, 3);
    release_rst(0);
    #1 chk("first_fetch_req", {31'b0, mem_req}, 32'd1);
    chk("first_fetch_addr", mem_addr, 32'h3000);
    drain("t1_drain", 60);
`ifdef MCCPU_DEBUG_EN
    reg_sel = 5'd3; #1 chk("dbg_r3", reg_data, 32'd2);
`endif
    assert_rst();

    // Two wait states per request: sw/lw round trip through data memory.
    clear_prog();
    put(32'h3000, ei(6'h09, 5'd0, 5'd3, 16'd2));
    put(32'h3004, ei(6'h2B, 5'd0, 5'd3, 16'h0000));
    put(32'h3008, ei(6'h23, 5'd0, 5'd4, 16'h0000));
    put(32'h300C, ei(6'h2B, 5'd0, 5'd4, 16'h0004));
    put(32'h3010, SELF);
    push_ret(32'h3000, 0);
    push_wr(32'h0, 32'd2); push_ret(32'h3004, 8);
    push_ret(32'h3008, 9);
    push_wr(32'h4, 32'd2); push_ret(32'h300C, 8);
    push_ret(32'h3010, 5); push_ret(32'h3010, 5);
    release_rst(2);
    drain("t2_drain", 120);
    assert_rst();

    // Branch fall-through, jal/jr linkage and r0 write suppression.
    clear_prog();
    put(32'h3000, ei(6'h09, 5'd0, 5'd1, 16'd1));
    put(32'h3004, ei(6'h09, 5'd0, 5'd0, 16'd7));
    put(32'h3008, ei(6'h05, 5'd1, 5'd1, 16'd5));
    put(32'h300C, ej(6'h03, 32'h0000_3100));
    put(32'h3100, er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h3010, ei(6'h2B, 5'd0, 5'd31, 16'h0008));
    put(32'h3014, ei(6'h2B, 5'd0, 5'd0, 16'h000C));
    put(32'h3018, SELF);
    push_ret(32'h3000, 0); push_ret(32'h3004, 4); push_ret(32'h3008, 3);
    push_ret(32'h300C, 3); push_ret(32'h3100, 3);
    push_wr(32'h8, 32'h3010); push_ret(32'h3010, 4);
    push_wr(32'hC, 32'h0); push_ret(32'h3014, 4);
    push_ret(32'h3018, 3); push_ret(32'h3018, 3);
    release_rst(0);
    drain("t3_drain", 80);
`ifdef MCCPU_DEBUG_EN
    reg_sel = 5'd0;  #1 chk("dbg_r0", reg_data, 32'd0);
    reg_sel = 5'd31; #1 chk("dbg_r31", reg_data, 32'h3010);
`endif
    assert_rst();

    // ALU coverage: lui/ori/slt/sll/srl/subu/and/or, unaligned sw, ori zero-extend.
    clear_prog();
    put(32'h3000, ei(6'h09, 5'd0, 5'd1, 16'd1));
    put(32'h3004, ei(6'h0F, 5'd0, 5'd5, 16'h8000));
    put(32'h3008, ei(6'h0D, 5'd5, 5'd5, 16'h00F0));
    put(32'h300C, er(5'd5, 5'd1, 5'd6, 5'd0, 6'h2A));
    put(32'h3010, er(5'd0, 5'd1, 5'd7, 5'd4, 6'h00));
    put(32'h3014, er(5'd0, 5'd5, 5'd8, 5'd4, 6'h02));
    put(32'h3018, er(5'd1, 5'd5, 5'd9, 5'd0, 6'h23));
    put(32'h301C, er(5'd5, 5'd9, 5'd10, 5'd0, 6'h24));
    put(32'h3020, er(5'd7, 5'd6, 5'd11, 5'd0, 6'h25));
    put(32'h3024, ei(6'h2B, 5'd0, 5'd6, 16'h0020));
    put(32'h3028, ei(6'h2B, 5'd0, 5'd8, 16'h0024));
    put(32'h302C, ei(6'h2B, 5'd0, 5'd9, 16'h0028));
    put(32'h3030, ei(6'h2B, 5'd0, 5'd10, 16'h002C));
    put(32'h3034, ei(6'h2B, 5'd0, 5'd11, 16'h0033));
    put(32'h3038, ei(6'h0D, 5'd0, 5'd12, 16'h8001));
    put(32'h303C, ei(6'h2B, 5'd0, 5'd12, 16'h0034));
    put(32'h3040, SELF);
    for (int i = 0; i < 9; i++) push_ret(32'h3000 + 32'(4 * i), (i == 0) ? 0 : 4);
    push_wr(32'h20, 32'h0000_0001); push_ret(32'h3024, 4);
    push_wr(32'h24, 32'h0800_000F); push_ret(32'h3028, 4);
    push_wr(32'h28, 32'h7FFF_FF11); push_ret(32'h302C, 4);
    push_wr(32'h2C, 32'h0000_0010); push_ret(32'h3030, 4);
    push_wr(32'h30, 32'h0000_0011); push_ret(32'h3034, 4);
    push_ret(32'h3038, 4);
    push_wr(32'h34, 32'h0000_8001); push_ret(32'h303C, 4);
    push_ret(32'h3040, 3); push_ret(32'h3040, 3);
    release_rst(0);
    drain("t4_drain", 150);
    assert_rst();

    // Illegal opcode 0x3F halts with no retire; reset restarts at RESET_PC.
    clear_prog();
    put(32'h3000, ei(6'h09, 5'd0, 5'd1, 16'd1));
    put(32'h3004, 32'hFC00_0000);
    push_ret(32'h3000, 0);
    release_rst(0);
    drain("t5_drain", 20);
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    chk("halted_set", {31'b0, halted}, 32'd1);
    repeat (4) @(negedge clk);
    #2;
    chk("halt_mem_req", {31'b0, mem_req}, 32'd0);
    chk("halt_absorbing", {31'b0, halted}, 32'd1);
    rst = 1'b1;
    #1 chk("halt_cleared", {31'b0, halted}, 32'd0);
    repeat (2) @(negedge clk);
    push_ret(32'h3000, 0);
    release_rst(0);
    #1 chk("restart_addr", mem_addr, 32'h3000);
    chk("restart_req", {31'b0, mem_req}, 32'd1);
    drain("t5b_drain", 20);
    assert_rst();

    // Reset during a waiting store aborts it; the store is never issued.
    clear_prog();
    put(32'h3000, ei(6'h2B, 5'd0, 5'd0, 16'h0040));
    release_rst(3);
    for (int i = 0; i < 30 && !(mem_req && mem_we); i++) begin
      @(negedge clk); #2;
    end
    chk("reach_mem_we", {31'b0, mem_we}, 32'd1);
    chk("reach_mem_addr", mem_addr, 32'h40);
    rst = 1'b1;
    #1 chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    repeat (2) @(negedge clk);
    put(32'h3000, SELF);
    push_ret(32'h3000, 0); push_ret(32'h3000, 3);
    release_rst(0);
    #1 chk("abort_refetch", mem_addr, 32'h3000);
    drain("t6_drain", 30);
    assert_rst();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
